// File: rtl/fan_pkg.sv
// Shared definitions for the fan speed controller: speed encoding,
// default PWM timing constants and the speed-advance rule.
package fan_pkg;

    typedef enum logic [1:0] {
        SPEED_OFF  = 2'd0,
        SPEED_LOW  = 2'd1,
        SPEED_MID  = 2'd2,
        SPEED_HIGH = 2'd3
    } speed_e;

    localparam int DEF_PWM_PERIOD = 1000;
    localparam int DEF_DUTY_LOW   = 250;
    localparam int DEF_DUTY_MID   = 500;
    localparam int DEF_DUTY_HIGH  = 1000;

    // Speed button cycles OFF -> LOW -> MID -> HIGH -> OFF.
    function automatic speed_e next_speed(input speed_e cur);
        speed_e nxt;
        case (cur)
            SPEED_OFF:  nxt = SPEED_LOW;
            SPEED_LOW:  nxt = SPEED_MID;
            SPEED_MID:  nxt = SPEED_HIGH;
            default:    nxt = SPEED_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_generator.sv
// Free-running PWM: period counter, period-aligned duty register and a
// registered compare. The duty input is only sampled at the end of a
// period so a duty change never produces a truncated or stretched pulse.
module pwm_generator
    import fan_pkg::*;
#(
    parameter int PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int CNT_W      = $clog2(PWM_PERIOD + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] duty_q;
    logic             pwm_q;

    // Period counter wraps at LAST_COUNT; duty is latched on that same cycle
    // so the new value governs the period that starts at count 0. The output
    // is the registered compare, one cycle behind the counter. Duty 0 never
    // matches and duty >= PWM_PERIOD always matches, since count < PWM_PERIOD.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
            duty_q  <= '0;
            pwm_q   <= 1'b0;
        end else begin
            if (count_q == LAST_COUNT) begin
                count_q <= '0;
                duty_q  <= i_duty;
            end else begin
                count_q <= count_q + 1'b1;
            end
            pwm_q <= (count_q < duty_q);
        end
    end

    assign o_pwm = pwm_q;

endmodule

// File: rtl/fan_speed_controller.sv
// Fan speed controller: button-driven speed FSM, one-hot LED decode and
// a PWM motor drive whose duty follows the selected speed.
//
//   state      | meaning
//   -----------+-------------------------------------------
//   SPEED_OFF  | motor off, duty 0
//   SPEED_LOW  | low speed, duty DUTY_LOW
//   SPEED_MID  | medium speed, duty DUTY_MID
//   SPEED_HIGH | high speed, duty DUTY_HIGH
//
// Stop has priority over speed when both pulses land in the same cycle.
module fan_speed_controller
    import fan_pkg::*;
#(
    parameter int PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int DUTY_LOW   = DEF_DUTY_LOW,
    parameter int DUTY_MID   = DEF_DUTY_MID,
    parameter int DUTY_HIGH  = DEF_DUTY_HIGH
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_speed_pulse,
    input  logic       i_stop_pulse,
    output logic [1:0] o_speed,
    output logic [3:0] o_led,
    output logic       o_pwm
);

    localparam int CNT_W = $clog2(PWM_PERIOD + 1);

    speed_e           speed_q;
    speed_e           speed_d;
    logic [CNT_W-1:0] duty_sel;

    // Speed state register; pulses arriving with reset are discarded.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            speed_q <= SPEED_OFF;
        end else begin
            speed_q <= speed_d;
        end
    end

    // Next speed: stop overrides, otherwise each speed pulse advances once.
    always_comb begin
        speed_d = speed_q;
        if (i_stop_pulse) begin
            speed_d = SPEED_OFF;
        end else if (i_speed_pulse) begin
            speed_d = next_speed(speed_q);
        end
    end

    // Duty lookup for the current speed; applied by the PWM at period start.
    always_comb begin
        duty_sel = '0;
        case (speed_q)
            SPEED_LOW:  duty_sel = CNT_W'(DUTY_LOW);
            SPEED_MID:  duty_sel = CNT_W'(DUTY_MID);
            SPEED_HIGH: duty_sel = CNT_W'(DUTY_HIGH);
            default:    duty_sel = '0;
        endcase
    end

    // One-hot LED straight from the speed register, no extra latency.
    always_comb begin
        o_led = 4'b0000;
        o_led[speed_q] = 1'b1;
    end

    assign o_speed = speed_q;

    pwm_generator #(
        .PWM_PERIOD (PWM_PERIOD),
        .CNT_W      (CNT_W)
    ) u_pwm (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_duty  (duty_sel),
        .o_pwm   (o_pwm)
    );

endmodule

// File: tb/tb_fan_speed_controller.sv
// Scoreboard bench for fan_speed_controller: the stimulus process drives
// directed pulses and queues the expected outputs for each cycle; the
// monitor pops and compares on every falling edge.
module tb_fan_speed_controller;

    logic       i_clk;
    logic       i_reset;
    logic       i_speed_pulse;
    logic       i_stop_pulse;
    logic [1:0] o_speed;
    logic [3:0] o_led;
    logic       o_pwm;

    fan_speed_controller #(
        .PWM_PERIOD (1000),
        .DUTY_LOW   (250),
        .DUTY_MID   (500),
        .DUTY_HIGH  (1000)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_speed_pulse (i_speed_pulse),
        .i_stop_pulse  (i_stop_pulse),
        .o_speed       (o_speed),
        .o_led         (o_led),
        .o_pwm         (o_pwm)
    );

    typedef struct {
        int         cyc;
        logic [1:0] spd;
        logic [3:0] led;
        logic       pwm;
        bit         chk_spd;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    logic [3:0] led_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    // Duty active in period k (period k starts at the counter wrap at phase k*1000).
    int duty_tab [12] = '{0, 0, 0, 250, 250, 250, 500, 0, 1000, 1000, 1000, 500};
    int spd_at   [12] = '{10, 20, 30, 40, 2500, 5401, 6600, 7100, 7110, 7120, 10060, 10070};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [1:0] s, input logic p, input bit chk);
        exp_t e;
        e.cyc     = c;
        e.spd     = s;
        e.led     = led_tab[s];
        e.pwm     = p;
        e.chk_spd = chk;
        sb.push_back(e);
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    always @(negedge i_clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (o_pwm !== e.pwm) begin
                n_bad++;
                $display("FAIL pwm cyc=%0d got=%b exp=%b", e.cyc, o_pwm, e.pwm);
            end
            if (e.chk_spd) begin
                n_vec++;
                if (o_speed !== e.spd) begin
                    n_bad++;
                    $display("FAIL speed cyc=%0d got=%0d exp=%0d", e.cyc, o_speed, e.spd);
                end
                n_vec++;
                if (o_led !== e.led) begin
                    n_bad++;
                    $display("FAIL led cyc=%0d got=%b exp=%b", e.cyc, o_led, e.led);
                end
            end
        end
    end

    initial begin
        int         r0;
        int         r1;
        logic [1:0] exp_spd;
        logic       exp_pwm;
        bit         hit;

        i_reset       = 1'b1;
        i_speed_pulse = 1'b1;
        i_stop_pulse  = 1'b0;
        // Reset values, including a speed pulse held during reset.
        for (int k = 1; k <= 3; k++) push(k, 2'd0, 1'b0, 1'b1);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        r0      = cyc;
        exp_spd = 2'd0;

        // Phase p = edges since reset release; counter after edge p is p mod 1000.
        for (int p = 1; p <= 11600; p++) begin
            hit = 1'b0;
            foreach (spd_at[j]) if (spd_at[j] == p) hit = 1'b1;
            i_speed_pulse = hit;
            i_stop_pulse  = (p == 6600) || (p == 10050);
            case (p)
                10:    exp_spd = 2'd1;
                20:    exp_spd = 2'd2;
                30:    exp_spd = 2'd3;
                40:    exp_spd = 2'd0;
                2500:  exp_spd = 2'd1;
                5401:  exp_spd = 2'd2;
                6600:  exp_spd = 2'd0;
                7100:  exp_spd = 2'd1;
                7110:  exp_spd = 2'd2;
                7120:  exp_spd = 2'd3;
                10050: exp_spd = 2'd0;
                10060: exp_spd = 2'd1;
                10070: exp_spd = 2'd2;
                default: ;
            endcase
            exp_pwm = (((p - 1) % 1000) < duty_tab[(p - 1) / 1000]);
            push(r0 + p, exp_spd, exp_pwm, 1'b1);
            @(negedge i_clk);
        end

        // Reset at counter 600 in MID, with a coinciding speed pulse.
        i_reset       = 1'b1;
        i_speed_pulse = 1'b1;
        i_stop_pulse  = 1'b0;
        push(cyc + 1, 2'd0, 1'b0, 1'b1);
        @(negedge i_clk);
        i_reset       = 1'b0;
        i_speed_pulse = 1'b0;
        r1            = cyc;
        for (int p = 1; p <= 1001; p++) begin
            push(r1 + p, 2'd0, 1'b0, 1'b1);
            @(negedge i_clk);
        end

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge i_clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
